// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter: N_REQ requesters, one shared FIFO write port.
// Ports: req_valid/req_last/req_data in, req_ready out; fifo_full in; w_valid/data_in/grant_id/busy/pkt_overrun out.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 64,
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   w_valid,
  output logic [WIDTH-1:0]       data_in,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                   busy,
  output logic                   pkt_overrun
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   pick;
  logic [GW:0]     idx;
  logic            found;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovr_q, ovr_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] gdata;
  logic            gvalid;
  logic            glast;

  // Round-robin search starting one past the last released grant.
  // idx carries an extra bit so last+i never wraps before the mod step.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = {1'b0, last_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_REQ))
        idx = idx - (GW+1)'(N_REQ);
      if (!found && req_valid[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

  assign gvalid = req_valid[grant_q];
  assign glast  = req_last[grant_q];
  assign gdata  = req_data[int'(grant_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    w_valid   = 1'b0;
    req_ready = '0;
    busy      = 1'b0;
    data_in   = hold_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        busy               = 1'b1;
        data_in            = gdata;
        w_valid            = gvalid & ~fifo_full;
        req_ready[grant_q] = ~fifo_full;
        if (w_valid) begin
          cnt_d = cnt_q + CW'(1);
          // Release on the real last beat, or force it at the beat cap.
          if (glast || cnt_d == CW'(MAX_BEATS)) begin
            state_d = IDLE;
            last_d  = grant_q;
            if (!glast)
              ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      hold_q  <= data_in;
    end
  end

  assign grant_id    = grant_q;
  assign pkt_overrun = ovr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus random packets.
// Checks against a rule-level arbitration model and a FIFO-content scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] v = '0;
  logic [N-1:0] l = '0;
  logic [W-1:0] dat [N];
  logic [N*W-1:0] req_data;
  logic         full = 1'b0;
  logic [N-1:0] req_ready;
  logic         w_valid;
  logic [W-1:0] data_in;
  logic [1:0]   grant_id;
  logic         busy;
  logic         pkt_overrun;

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v), .req_last(l), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(full),
    .w_valid(w_valid), .data_in(data_in), .grant_id(grant_id),
    .busy(busy), .pkt_overrun(pkt_overrun)
  );

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign req_data[k*W +: W] = dat[k];
  end

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model
  int m_busy, m_g, m_last, m_cnt;
  bit m_ovr;
  logic [N-1:0] acc;
  int nwr [N];
  bit sb_on = 1'b0;
  logic [W-1:0] fq [$];
  int gq [$];

  task automatic check(input string tag, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_g    = 0;
    m_last = N - 1;
    m_cnt  = 0;
    m_ovr  = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_busy", W'(busy), 0);
    check("rst_wvalid", W'(w_valid), 0);
    check("rst_ready", W'(req_ready), 0);
    check("rst_data", data_in, 0);
    check("rst_grant", W'(grant_id), 0);
    check("rst_ovr", W'(pkt_overrun), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One cycle: inputs already driven; check outputs, cross the edge,
  // then advance the model by the arbitration rules.
  task automatic step();
    logic [N-1:0] er;
    bit ew;
    bit fnd;
    int c;
    #2;
    ew = (m_busy != 0) && v[2'(m_g)] && !full;
    er = '0;
    if (m_busy != 0 && !full) er[2'(m_g)] = 1'b1;
    check("busy", W'(busy), W'(m_busy));
    check("w_valid", W'(w_valid), W'(ew));
    check("req_ready", W'(req_ready), W'(er));
    check("grant_id", W'(grant_id), W'(m_g));
    check("pkt_overrun", W'(pkt_overrun), W'(m_ovr));
    if (m_busy != 0) check("data_in", data_in, dat[m_g]);
    if (w_valid === 1'b1) begin
      gq.push_back(int'(grant_id));
      if (sb_on) fq.push_back(data_in);
    end
    acc = '0;
    if (ew) begin
      acc[2'(m_g)] = 1'b1;
      nwr[m_g]++;
    end
    @(posedge clk);
    #1;
    if (m_busy == 0) begin
      if (v != '0) begin
        fnd = 1'b0;
        for (int i = 1; i <= N; i++) begin
          c = (m_last + i) % N;
          if (!fnd && v[2'(c)]) begin
            m_g = c;
            fnd = 1'b1;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (ew) begin
      m_cnt++;
      if (l[2'(m_g)] || m_cnt == MB) begin
        if (!l[2'(m_g)]) m_ovr = 1'b1;
        m_last = m_g;
        m_busy = 0;
      end
    end
  endtask

  task automatic rnd_data();
    for (int k = 0; k < N; k++) dat[k] = {$urandom, $urandom};
  endtask

  bit pres [N];
  int rem [N];
  int sq [N];
  int cntk [N];
  int base;
  int exp_ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int k = 0; k < N; k++) begin
      dat[k] = '0;
      nwr[k] = 0;
      pres[k] = 1'b0;
      rem[k] = 0;
      sq[k] = 0;
      cntk[k] = 0;
    end
    model_reset();
    #2;
    reset_pulse();

    // two requesters; 1 wins first, 3-beat packet, then 3
    v = 4'b1010;
    base = nwr[1];
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      l = {1'b1, 1'b0, (nwr[1] - base == 2), 1'b0};
      step();
    end
    check("d1_beats", W'(nwr[1] - base), 3);
    check("d1_grant3", W'(grant_id), 3);
    l = 4'b1000;
    step();
    v = '0;
    step();

    // all requesters, 1-beat packets
    gq.delete();
    v = 4'b1111;
    l = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      rnd_data();
      step();
    end
    v = '0;
    step();
    check("rr_count", W'(gq.size()), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      check("rr_order", W'(gq[i]), W'(exp_ord[i]));

    // stall mid-packet on requester 2
    base = nwr[2];
    v = 4'b0100;
    l = '0;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step();
    end
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      step();
    end
    full = 1'b0;
    rnd_data();
    step();
    l = 4'b0100;
    rnd_data();
    step();
    v = '0;
    step();
    check("stall_beats", W'(nwr[2] - base), 4);

    // forced release at the beat cap
    v = 4'b0101;
    l = 4'b0100;
    base = nwr[0];
    for (int i = 0; i < MB + 1; i++) begin
      rnd_data();
      step();
    end
    check("ovr_beats", W'(nwr[0] - base), MB);
    check("ovr_set", W'(pkt_overrun), 1);
    check("ovr_idle", W'(busy), 0);
    step();
    check("ovr_next", W'(grant_id), 2);
    step();
    v = '0;
    step();

    // reset in the middle of a packet on requester 3
    v = 4'b1000;
    l = '0;
    rnd_data();
    step();
    rnd_data();
    step();
    rnd_data();
    #2;
    reset_pulse();
    v = 4'b1001;
    l = 4'b1001;
    step();
    check("rst_rr", W'(grant_id), 0);
    step();
    v = '0;
    step();

    // random packets
    begin
      int pk;
      int cyc;
      pk = 0;
      cyc = 0;
      sb_on = 1'b1;
      while (pk < 2000 && cyc < 80000) begin
        for (int k = 0; k < N; k++) begin
          if (!pres[k] && $urandom_range(0, 7) != 0) begin
            pres[k] = 1'b1;
            if (rem[k] == 0) rem[k] = $urandom_range(1, 16);
          end
          v[k] = pres[k];
          l[k] = (rem[k] == 1);
          dat[k] = {32'(k), 32'(sq[k])};
        end
        full = ($urandom_range(0, 3) == 0);
        step();
        for (int k = 0; k < N; k++) begin
          if (acc[k]) begin
            pres[k] = 1'b0;
            sq[k]++;
            rem[k]--;
            if (rem[k] == 0) pk++;
          end
        end
        cyc++;
      end
      check("rand_done", W'(pk >= 2000), 1);
      v = '0;
      full = 1'b0;
      sb_on = 1'b0;
      foreach (fq[i]) begin
        int rid;
        rid = int'(fq[i][63:32]);
        if (rid >= 0 && rid < N) begin
          check("sb_seq", W'(fq[i][31:0]), W'(cntk[rid]));
          cntk[rid]++;
        end else begin
          check("sb_rid", W'(rid), 0);
        end
      end
      for (int k = 0; k < N; k++)
        check("sb_count", W'(cntk[k]), W'(sq[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, data width of each requester and of the FIFO write port.
REQ-002 Parameter N_REQ, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter MAX_BEATS, default 16, maximum beats per packet before a forced release.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  N_REQ  per-requester beat valid.
REQ-007 req_last  input  N_REQ  per-requester last-beat-of-packet flag; qualified by req_valid.
REQ-008 req_data  input  N_REQ*WIDTH  packed beat data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-009 req_ready  output  N_REQ  per-requester beat accepted this cycle.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 w_valid  output  1  FIFO write strobe; one write per cycle when high.
REQ-012 data_in  output  WIDTH  FIFO write data.
REQ-013 grant_id  output  clog2(N_REQ)  index of the currently locked requester.
REQ-014 busy  output  1  high while in state LOCK.
REQ-015 pkt_overrun  output  1  sticky flag: a forced release has occurred.

Function
REQ-016 The block SHALL use a two-state FSM, IDLE and LOCK.
REQ-017 In IDLE, w_valid, busy and all req_ready bits SHALL be 0.
REQ-018 In IDLE, when any req_valid is high, the block SHALL register grant_id as the first requester with req_valid high, searching round-robin from last_grant+1 (mod N_REQ), and SHALL enter LOCK on the next edge.
REQ-019 Arbitration SHALL cost exactly one cycle, so the first beat of a packet transfers no earlier than the cycle after the request is seen in IDLE.
REQ-020 In LOCK with g=grant_id: w_valid = req_valid[g] & !fifo_full; req_ready[g] = !fifo_full; req_ready for every other requester = 0.
REQ-021 In LOCK, data_in SHALL equal req_data[g] combinationally; in IDLE, data_in SHALL hold its previous value, and its value is ignored while w_valid is 0.
REQ-022 A beat transfers on any edge where w_valid is 1; a beat counter (clog2(MAX_BEATS+1) bits) SHALL increment on each transfer and clear on entry to LOCK.
REQ-023 A transfer with req_last[g]=1 SHALL return the FSM to IDLE and set last_grant=g.
REQ-024 A transfer that makes the beat count equal MAX_BEATS with req_last[g]=0 SHALL return the FSM to IDLE, set last_grant=g and set pkt_overrun=1.
REQ-025 While fifo_full=1 in LOCK, no transfer occurs and the FSM, the beat counter and grant_id SHALL hold.
REQ-026 If req_valid[g] drops mid-packet, the block SHALL stay in LOCK on g; other requesters SHALL NOT be granted until release.
REQ-027 A requester that holds req_valid high while not granted SHALL NOT be starved: it is granted within N_REQ-1 packet completions.
REQ-028 req_valid and req_last of non-granted requesters SHALL have no effect in LOCK.
REQ-029 fifo_full rising in the same cycle as the last beat SHALL block that beat; release occurs only on the edge where the last beat actually transfers.

Reset
REQ-030 On rst_n=0, the block SHALL asynchronously set state=IDLE, grant_id=0, last_grant=N_REQ-1, beat counter=0, pkt_overrun=0 and data_in=0; w_valid, busy and req_ready SHALL become 0 immediately.
REQ-031 On reset asserted mid-packet, the partial packet SHALL be abandoned, and after release the first grant SHALL search from requester 0.
REQ-032 pkt_overrun SHALL clear only on reset.

Verification
REQ-033 Reset, then req_valid=4'b1010 held -> grant_id=1 after 1 cycle; requester 1's 3-beat packet writes 3 FIFO entries; then 1 IDLE cycle; then grant_id=3.
REQ-034 All 4 requesters send 1-beat packets continuously -> grant order 0,1,2,3,0, with w_valid pulsing every second cycle.
REQ-035 Requester 2 is locked; fifo_full=1 for 5 cycles mid-packet -> w_valid=0 and req_ready=0 for those 5 cycles, the beat count holds, and no beat is lost or duplicated, checked by a scoreboard against FIFO contents.
REQ-036 Requester 0 sends 20 beats with no req_last, MAX_BEATS=16 -> release after beat 16, pkt_overrun=1, next grant goes to another pending requester.
REQ-037 rst_n is pulsed low during beat 2 of a packet on requester 3 -> outputs go to 0 immediately; after release, requester 0 is granted first when requesters 0 and 3 both request.
REQ-038 Random test of 2000 packets with random lengths 1..16, random valid gaps and random fifo_full -> the per-requester beat order in the FIFO matches the scoreboard exactly.
